// File: rtl/button_conditioner.sv
// button_conditioner
//   Turns two raw, bouncy, active-low push-buttons into clean press events.
//   Each button is synchronised, debounced and then run through a small FSM:
//     - one event per press
//     - auto-repeat events while the button stays held
//   Pressing both buttons together locks out all events until both are released.
//
// Ports
//   i_CLK        system clock
//   i_RST        asynchronous active-low reset
//   i_btn_inc    raw increment button, active-low, asynchronous to i_CLK
//   i_btn_dec    raw decrement button, active-low, asynchronous to i_CLK
//   o_inc_btn    active-low 1-cycle inc event, idle 1
//   o_dec_btn    active-low 1-cycle dec event, idle 1
//   o_inc_pulse  active-high copy of the inc event
//   o_dec_pulse  active-high copy of the dec event
//   o_inc_held   high while inc is auto-repeating
//   o_dec_held   high while dec is auto-repeating
//   o_lockout    high while the both-pressed lockout is active
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned HOLD_CYC     = 25000000,
    parameter int unsigned REPEAT_CYC   = 5000000,
    parameter int unsigned CNT_BITS     = 25
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_btn_inc,
    input  logic i_btn_dec,
    output logic o_inc_btn,
    output logic o_dec_btn,
    output logic o_inc_pulse,
    output logic o_dec_pulse,
    output logic o_inc_held,
    output logic o_dec_held,
    output logic o_lockout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REPEAT
    } state_t;

    localparam logic [CNT_BITS-1:0] DEB_LAST  = CNT_BITS'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(HOLD_CYC - 1);
    localparam logic [CNT_BITS-1:0] REP_LAST  = CNT_BITS'(REPEAT_CYC - 1);

    // Index 0 = inc, index 1 = dec throughout.
    logic [1:0]          raw;
    logic [1:0]          sync1, sync2;     // raw polarity (0 = pressed)
    logic [1:0]          deb_q, deb_d;     // 1 = pressed
    logic [CNT_BITS-1:0] deb_cnt_q [2];
    logic [CNT_BITS-1:0] deb_cnt_d [2];
    logic                lock_q, lock_d, lock_any;
    state_t              state_q [2];
    state_t              state_d [2];
    logic [CNT_BITS-1:0] tmr_q [2];
    logic [CNT_BITS-1:0] tmr_d [2];
    logic [1:0]          fire;
    logic [1:0]          pulse_q, pulse_d;
    logic [1:0]          held_q, held_d;

    assign raw = {i_btn_dec, i_btn_inc};

    // State register: synchroniser, debouncer, lockout and both FSMs.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            sync1   <= '1;
            sync2   <= '1;
            deb_q   <= '0;
            lock_q  <= 1'b0;
            pulse_q <= '0;
            held_q  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
                state_q[i]   <= S_IDLE;
                tmr_q[i]     <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            deb_q   <= deb_d;
            lock_q  <= lock_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
            for (int unsigned i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                state_q[i]   <= state_d[i];
                tmr_q[i]     <= tmr_d[i];
            end
        end
    end

    // Debounce and lockout next state.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            // sync2 is active-low, deb is active-high: equal means they disagree.
            if (sync2[i] == deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        // Lockout follows the debounced levels being written this edge, so it
        // rises together with the second press and drops with the last release.
        lock_d = lock_q;
        if (&deb_d) begin
            lock_d = 1'b1;
        end else if (~|deb_d) begin
            lock_d = 1'b0;
        end
    end

    assign lock_any = lock_q | lock_d;

    // Per-button FSM next state; release takes priority over a due repeat.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            tmr_d[i]   = tmr_q[i];
            fire[i]    = 1'b0;
            if (lock_any) begin
                state_d[i] = S_IDLE;
                tmr_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    S_IDLE: begin
                        if (deb_q[i]) begin
                            fire[i]    = 1'b1;
                            state_d[i] = S_WAIT;
                            tmr_d[i]   = '0;
                        end
                    end
                    S_WAIT: begin
                        if (!deb_q[i]) begin
                            state_d[i] = S_IDLE;
                            tmr_d[i]   = '0;
                        end else if (tmr_q[i] == HOLD_LAST) begin
                            fire[i]    = 1'b1;
                            state_d[i] = S_REPEAT;
                            tmr_d[i]   = '0;
                        end else begin
                            tmr_d[i] = tmr_q[i] + 1'b1;
                        end
                    end
                    S_REPEAT: begin
                        if (!deb_q[i]) begin
                            state_d[i] = S_IDLE;
                            tmr_d[i]   = '0;
                        end else if (tmr_q[i] == REP_LAST) begin
                            fire[i]  = 1'b1;
                            tmr_d[i] = '0;
                        end else begin
                            tmr_d[i] = tmr_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                        tmr_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Output next values (registered in the state register block).
    always_comb begin
        pulse_d = '0;
        held_d  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            pulse_d[i] = fire[i];
            held_d[i]  = (state_d[i] == S_REPEAT);
        end
    end

    assign o_inc_btn   = ~pulse_q[0];
    assign o_dec_btn   = ~pulse_q[1];
    assign o_inc_pulse = pulse_q[0];
    assign o_dec_pulse = pulse_q[1];
    assign o_inc_held  = held_q[0];
    assign o_dec_held  = held_q[1];
    assign o_lockout   = lock_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYC=4, HOLD_CYC=10,
//   REPEAT_CYC=5. Each scenario record gives per-edge raw-low masks for both
//   buttons and per-edge expected masks for events, held flags and lockout
//   (bit k = value registered at edge k, edge 0 = first edge sampling the
//   scenario's inputs).
module tb_button_conditioner;

    logic i_CLK = 1'b0;
    logic i_RST = 1'b0;
    logic i_btn_inc = 1'b1;
    logic i_btn_dec = 1'b1;
    logic o_inc_btn, o_dec_btn, o_inc_pulse, o_dec_pulse;
    logic o_inc_held, o_dec_held, o_lockout;

    int n_cmp = 0;
    int n_err = 0;

    button_conditioner #(
        .DEBOUNCE_CYC(4),
        .HOLD_CYC    (10),
        .REPEAT_CYC  (5),
        .CNT_BITS    (8)
    ) dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_btn_inc  (i_btn_inc),
        .i_btn_dec  (i_btn_dec),
        .o_inc_btn  (o_inc_btn),
        .o_dec_btn  (o_dec_btn),
        .o_inc_pulse(o_inc_pulse),
        .o_dec_pulse(o_dec_pulse),
        .o_inc_held (o_inc_held),
        .o_dec_held (o_dec_held),
        .o_lockout  (o_lockout)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        string       name;
        logic [63:0] inc_lo;
        logic [63:0] dec_lo;
        logic [63:0] inc_ev;
        logic [63:0] dec_ev;
        logic [63:0] inc_held;
        logic [63:0] dec_held;
        logic [63:0] lock;
        int          ncyc;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] at(input int k);
        logic [63:0] m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mk(input string n, input logic [63:0] il, input logic [63:0] dl,
                                input logic [63:0] ie, input logic [63:0] de,
                                input logic [63:0] ih, input logic [63:0] dh,
                                input logic [63:0] lk, input int nc);
        vec_t v;
        v.name = n; v.inc_lo = il; v.dec_lo = dl; v.inc_ev = ie; v.dec_ev = de;
        v.inc_held = ih; v.dec_held = dh; v.lock = lk; v.ncyc = nc;
        return v;
    endfunction

    task automatic chk(input string scen, input string sig, input int k,
                       input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s edge %0d: got %b want %b", scen, sig, k, act, exp);
        end
    endtask

    task automatic check_all(input string scen, input int k, input logic ie, input logic de,
                             input logic ih, input logic dh, input logic lk);
        chk(scen, "o_inc_pulse", k, o_inc_pulse, ie);
        chk(scen, "o_inc_btn",   k, o_inc_btn,   ~ie);
        chk(scen, "o_dec_pulse", k, o_dec_pulse, de);
        chk(scen, "o_dec_btn",   k, o_dec_btn,   ~de);
        chk(scen, "o_inc_held",  k, o_inc_held,  ih);
        chk(scen, "o_dec_held",  k, o_dec_held,  dh);
        chk(scen, "o_lockout",   k, o_lockout,   lk);
    endtask

    // Called at posedge+1; drives inputs for edge k then checks after edge k.
    task automatic run_vec(input vec_t v);
        for (int k = 0; k < v.ncyc; k++) begin
            i_btn_inc = ~v.inc_lo[k];
            i_btn_dec = ~v.dec_lo[k];
            @(posedge i_CLK);
            #1;
            check_all(v.name, k, v.inc_ev[k], v.dec_ev[k], v.inc_held[k], v.dec_held[k], v.lock[k]);
        end
        i_btn_inc = 1'b1;
        i_btn_dec = 1'b1;
    endtask

    initial begin
        logic [63:0] ev;
        logic [63:0] hd;

        vecs[0] = mk("idle",    '0, '0, '0, '0, '0, '0, '0, 20);
        vecs[1] = mk("inc8",    rng(0, 7), '0, at(6), '0, '0, '0, '0, 30);
        vecs[2] = mk("bounce",  rng(0, 1) | at(3) | rng(5, 7) | at(9) | at(11), '0,
                     '0, '0, '0, '0, '0, 30);
        vecs[3] = mk("glitch3", rng(0, 2), '0, '0, '0, '0, '0, '0, 20);
        vecs[4] = mk("glitch4", rng(0, 3), '0, at(6), '0, '0, '0, '0, 20);
        vecs[5] = mk("dec40",   '0, rng(0, 39), '0,
                     at(6) | at(16) | at(21) | at(26) | at(31) | at(36) | at(41),
                     '0, rng(16, 45), '0, 60);
        vecs[6] = mk("lock",    rng(0, 29), rng(2, 31), at(6), '0, '0, '0, rng(7, 36), 50);
        vecs[7] = mk("both",    rng(0, 9), rng(0, 9), '0, '0, '0, '0, rng(5, 14), 30);

        // Reset state while reset is held.
        repeat (3) @(posedge i_CLK);
        #1;
        check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_RST = 1'b1;

        for (int s = 0; s < 8; s++) run_vec(vecs[s]);

        // Reset during inc auto-repeat, button kept held throughout.
        ev = at(6) | at(16) | at(21);
        hd = rng(16, 63);
        i_btn_inc = 1'b0;
        for (int k = 0; k <= 21; k++) begin
            @(posedge i_CLK);
            #1;
            check_all("pre_rst", k, ev[k], 1'b0, hd[k], 1'b0, 1'b0);
        end
        #2;
        i_RST = 1'b0;
        #1;
        check_all("mid_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge i_CLK);
        @(posedge i_CLK);
        #1;
        check_all("mid_rst", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_RST = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge i_CLK);
            #1;
            check_all("post_rst", k, ev[k], 1'b0, hd[k], 1'b0, 1'b0);
        end
        i_btn_inc = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
